// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : cpu_pkg
//  Purpose  : Physical-register geometry shared by rename, ROB and free list.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int PREG_W   = 6;
    localparam int NUM_PREG = 64;
    localparam int NUM_ARCH = 32;

    typedef logic [PREG_W-1:0] preg_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/phys_free_list_fl_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fl_ram
//  Purpose  : Free-list entry storage: one async read port, two write ports,
//             reset-loaded with the initially unmapped physical registers.
//  Revision : 1.0  initial release
// ============================================================================
module fl_ram #(
    parameter int DEPTH    = cpu_pkg::NUM_PREG,
    parameter int ADDR_W   = $clog2(cpu_pkg::NUM_PREG),
    parameter int RST_FILL = cpu_pkg::NUM_PREG - cpu_pkg::NUM_ARCH,
    parameter int RST_BASE = cpu_pkg::NUM_ARCH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [cpu_pkg::PREG_W-1:0] rd_data,
    input  logic                      wr_en_a,
    input  logic [ADDR_W-1:0]         wr_addr_a,
    input  logic [cpu_pkg::PREG_W-1:0] wr_data_a,
    input  logic                      wr_en_b,
    input  logic [ADDR_W-1:0]         wr_addr_b,
    input  logic [cpu_pkg::PREG_W-1:0] wr_data_b
);
    import cpu_pkg::*;

    preg_t mem_q [DEPTH];
    preg_t mem_d [DEPTH];

    assign rd_data = mem_q[rd_addr];

    // The control logic never targets the same address on both ports.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_a) mem_d[wr_addr_a] = wr_data_a;
        if (wr_en_b) mem_d[wr_addr_b] = wr_data_b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < RST_FILL) ? PREG_W'(RST_BASE + i) : '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule : fl_ram
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : phys_free_list
//  Purpose  : Circular free list of physical registers; one allocation and up
//             to two ROB frees per cycle. Optional duplicate-free detection is
//             built when FREELIST_DUP_CHECK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module phys_free_list #(
    parameter int  NUM_PREG = cpu_pkg::NUM_PREG,
    parameter int  NUM_ARCH = cpu_pkg::NUM_ARCH,
    localparam int PTR_W    = $clog2(NUM_PREG),
    localparam int CNT_W    = $clog2(NUM_PREG + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       alloc_req,
    output logic                       alloc_gnt,
    output logic [cpu_pkg::PREG_W-1:0] alloc_preg,
    input  logic                       free_valid_1,
    input  logic [cpu_pkg::PREG_W-1:0] free_preg_1,
    input  logic                       free_valid_2,
    input  logic [cpu_pkg::PREG_W-1:0] free_preg_2,
    output logic [CNT_W-1:0]           free_count,
    output logic                       empty,
    output logic                       overflow_err,
    output logic                       dup_err
);
    import cpu_pkg::*;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    preg_t            head_preg;
    logic             want_1, want_2;
    logic             acc_1, acc_2;
    logic [CNT_W:0]   room;

    fl_ram #(
        .DEPTH    (NUM_PREG),
        .ADDR_W   (PTR_W),
        .RST_FILL (NUM_PREG - NUM_ARCH),
        .RST_BASE (NUM_ARCH)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr   (head_q),
        .rd_data   (head_preg),
        .wr_en_a   (acc_1),
        .wr_addr_a (tail_q),
        .wr_data_a (free_preg_1),
        .wr_en_b   (acc_2),
        .wr_addr_b (tail_q + PTR_W'(acc_1)),
        .wr_data_b (free_preg_2)
    );

    assign empty        = (count_q == '0);
    assign alloc_gnt    = alloc_req && !empty;
    assign alloc_preg   = head_preg;
    assign free_count   = count_q;
    assign overflow_err = ovf_q;

`ifdef FREELIST_DUP_CHECK_EN
    logic [NUM_PREG-1:0] in_list_q, in_list_d;
    logic                dup_q, dup_d;
    logic                dup_1, dup_2;

    // Slot 2 is also a duplicate when it names the same register as slot 1.
    assign dup_1  = free_valid_1 && (free_preg_1 != '0) && in_list_q[free_preg_1];
    assign dup_2  = free_valid_2 && (free_preg_2 != '0) &&
                    (in_list_q[free_preg_2] || (free_valid_1 && (free_preg_1 == free_preg_2)));
    assign want_1 = free_valid_1 && (free_preg_1 != '0) && !dup_1;
    assign want_2 = free_valid_2 && (free_preg_2 != '0) && !dup_2;
    assign dup_err = dup_q;

    always_comb begin
        in_list_d = in_list_q;
        dup_d     = dup_q || dup_1 || dup_2;
        if (alloc_gnt) in_list_d[head_preg]   = 1'b0;
        if (acc_1)     in_list_d[free_preg_1] = 1'b1;
        if (acc_2)     in_list_d[free_preg_2] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                in_list_q[i] <= (i >= NUM_ARCH);
            end
            dup_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            dup_q     <= dup_d;
        end
    end
`else
    assign want_1  = free_valid_1 && (free_preg_1 != '0);
    assign want_2  = free_valid_2 && (free_preg_2 != '0);
    assign dup_err = 1'b0;
`endif

    // Space includes the slot released by this cycle's pop; slot 2 loses first.
    always_comb begin
        room    = (CNT_W+1)'(NUM_PREG) - {1'b0, count_q} + (CNT_W+1)'(alloc_gnt);
        acc_1   = want_1 && (room != '0);
        acc_2   = want_2 && (room > (CNT_W+1)'(acc_1));
        head_d  = head_q + PTR_W'(alloc_gnt);
        tail_d  = tail_q + PTR_W'(acc_1) + PTR_W'(acc_2);
        count_d = count_q - CNT_W'(alloc_gnt) + CNT_W'(acc_1) + CNT_W'(acc_2);
        ovf_d   = ovf_q || (want_1 && !acc_1) || (want_2 && !acc_2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= PTR_W'(NUM_PREG - NUM_ARCH);
            count_q <= CNT_W'(NUM_PREG - NUM_ARCH);
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule : phys_free_list
`default_nettype wire

// File: tb/tb_phys_free_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phys_free_list
//  Purpose  : Randomized and directed stimulus for phys_free_list, scored
//             against a queue-based reference list.
//  Revision : 1.0  initial release
// ============================================================================
module tb_phys_free_list;
    import cpu_pkg::*;

    localparam int NP = 64;
    localparam int NA = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [5:0] alloc_preg;
    logic       free_valid_1 = 1'b0;
    logic [5:0] free_preg_1 = '0;
    logic       free_valid_2 = 1'b0;
    logic [5:0] free_preg_2 = '0;
    logic [6:0] free_count;
    logic       empty;
    logic       overflow_err;
    logic       dup_err;

    phys_free_list #(.NUM_PREG(NP), .NUM_ARCH(NA)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_preg   (alloc_preg),
        .free_valid_1 (free_valid_1),
        .free_preg_1  (free_preg_1),
        .free_valid_2 (free_valid_2),
        .free_preg_2  (free_preg_2),
        .free_count   (free_count),
        .empty        (empty),
        .overflow_err (overflow_err),
        .dup_err      (dup_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit gnt;
        int preg;
        int cnt;
        bit ovf;
        bit dup;
    } exp_t;

    exp_t exp_q[$];
    int   fl[$];
    bit   m_ovf;
    bit   m_dup;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void chk(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit listed(int p);
        foreach (fl[i]) if (fl[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        fl.delete();
        for (int i = NA; i < NP; i++) fl.push_back(i);
        m_ovf = 1'b0;
        m_dup = 1'b0;
    endfunction

    // One cycle: record what the list should show now, then apply the cycle's effects.
    task automatic drive(bit req, bit v1, int p1, bit v2, int p2);
        exp_t e;
        bit   d1, d2;
        @(posedge clk);
        #1;
        alloc_req    = req;
        free_valid_1 = v1;
        free_preg_1  = 6'(p1);
        free_valid_2 = v2;
        free_preg_2  = 6'(p2);
        e.cnt  = fl.size();
        e.gnt  = req && (fl.size() > 0);
        e.preg = (fl.size() > 0) ? fl[0] : -1;
        e.ovf  = m_ovf;
        e.dup  = m_dup;
        exp_q.push_back(e);
        d1 = 1'b0;
        d2 = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
        d1 = v1 && (p1 != 0) && listed(p1);
        d2 = v2 && (p2 != 0) && (listed(p2) || (v1 && p1 == p2));
        m_dup = m_dup || d1 || d2;
`endif
        if (e.gnt) void'(fl.pop_front());
        if (v1 && p1 != 0 && !d1) begin
            if (fl.size() < NP) fl.push_back(p1);
            else m_ovf = 1'b1;
        end
        if (v2 && p2 != 0 && !d2) begin
            if (fl.size() < NP) fl.push_back(p2);
            else m_ovf = 1'b1;
        end
    endtask

    // Reset lands mid-cycle while a pop and two pushes are being presented.
    task automatic reset_mid();
        exp_t e;
        @(posedge clk);
        #1;
        alloc_req    = 1'b1;
        free_valid_1 = 1'b1;
        free_preg_1  = 6'd17;
        free_valid_2 = 1'b1;
        free_preg_2  = 6'd18;
        #2;
        reset_n      = 1'b0;
        alloc_req    = 1'b0;
        free_valid_1 = 1'b0;
        free_valid_2 = 1'b0;
        model_reset();
        e.cnt  = NP - NA;
        e.gnt  = 1'b0;
        e.preg = NA;
        e.ovf  = 1'b0;
        e.dup  = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alloc_gnt", int'(alloc_gnt), int'(e.gnt));
            chk("free_count", int'(free_count), e.cnt);
            chk("empty", int'(empty), int'(e.cnt == 0));
            chk("overflow_err", int'(overflow_err), int'(e.ovf));
            chk("dup_err", int'(dup_err), int'(e.dup));
            if (e.preg >= 0) chk("alloc_preg", int'(alloc_preg), e.preg);
        end
    end

    initial begin
        int p, q, guard;
        model_reset();
        #12;
        reset_n = 1'b1;

        // Three back-to-back allocations, then drain to empty and ask once more.
        repeat (3) drive(1, 0, 0, 0, 0);
        repeat (29) drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Frees into an empty list are not visible to the same-cycle request.
        drive(1, 1, 40, 1, 41);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // x0 is never recycled.
        drive(0, 1, 0, 1, 5);
        drive(0, 0, 0, 0, 0);

        // Fill to capacity, then overflow with two more frees.
        guard = 0;
        while (fl.size() < NP && guard < 200) begin
            p = $urandom_range(1, 63);
            q = $urandom_range(1, 63);
            drive(0, 1, p, 1, q);
            guard++;
        end
        drive(0, 1, 7, 1, 9);
        drive(1, 1, 11, 1, 12);
        repeat (4) drive(0, 0, 0, 0, 0);

        reset_mid();
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 50, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 21, 1, 21);
        drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r, v1, v2;
            int fill_bias;
            if (i == 1700) reset_mid();
            fill_bias = (i % 600 < 300) ? 75 : 25;
            r  = ($urandom_range(0, 99) < (100 - fill_bias));
            v1 = ($urandom_range(0, 99) < fill_bias);
            v2 = ($urandom_range(0, 99) < fill_bias);
            p  = $urandom_range(0, 63);
            q  = ($urandom_range(0, 9) == 0) ? p : $urandom_range(0, 63);
            drive(r, v1, p, v2, q);
        end
        drive(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_phys_free_list
`default_nettype wire

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter NUM_PREG, default 64, number of physical registers (free-list depth).
REQ-002 SHALL have parameter NUM_ARCH, default 32, physical regs 0..NUM_ARCH-1 mapped at reset, hence never initially free.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 alloc_req  input  1  rename stage requests one physical destination this cycle.
REQ-006 alloc_gnt  output  1  request granted; alloc_preg valid.
REQ-007 alloc_preg  output  6  physical register handed to rename/ROB alloc_dest.
REQ-008 free_valid_1  input  1  ROB commit slot 1 releases a register.
REQ-009 free_preg_1  input  6  register released by slot 1 (ROB free_oldDest_1).
REQ-010 free_valid_2  input  1  ROB commit slot 2 releases a register.
REQ-011 free_preg_2  input  6  register released by slot 2 (ROB free_oldDest_2).
REQ-012 free_count  output  7  number of entries currently in the list.
REQ-013 empty  output  1  free_count == 0.
REQ-014 overflow_err  output  1  sticky: a push was dropped because the list was full.
REQ-015 dup_err  output  1  sticky: duplicate free detected (tied 0 unless FREELIST_DUP_CHECK_EN).

Function
REQ-016 SHALL be a circular FIFO of NUM_PREG 6-bit entries with head, tail (6-bit, wrap 63->0) and 7-bit count.
REQ-017 alloc_preg SHALL be combinational from the entry at head; alloc_gnt = alloc_req && !empty.
REQ-018 A grant SHALL pop one entry at the next posedge (head+1 mod 64, count-1); zero-cycle allocation latency.
REQ-019 A free SHALL be pushed only if its free_valid is 1 and its preg != 0; preg 0 (x0) is never recycled.
REQ-020 Both valid frees in one cycle SHALL push in order slot 1 then slot 2 (tail, tail+1 mod 64).
REQ-021 Freed registers SHALL NOT be allocatable in the same cycle (no free-to-alloc bypass); visible next cycle.
REQ-022 Simultaneous grant and up to two pushes SHALL update count = count - gnt + pushes in one cycle.
REQ-023 Full: pushes that would make count exceed 64 SHALL be dropped (slot 2 dropped first) and overflow_err set; the pop in the same cycle frees space counted before drop decision.
REQ-024 Empty: alloc_gnt SHALL be 0 even when frees arrive that cycle (per REQ-021).
REQ-025 overflow_err and dup_err SHALL clear only on reset.

Reset
REQ-026 On reset_n low: entries 0..31 hold preg 32..63 in ascending order, head=0, tail=32, count=32, alloc_gnt=0, alloc_preg=32 once reset releases, empty=0, errors=0.
REQ-027 Reset asserted mid-operation SHALL immediately restore REQ-026 state, discarding in-flight pops/pushes.

Configuration
REQ-028 Macro FREELIST_DUP_CHECK_EN: when defined, a 64-bit in-list bitmap tracks membership; a free of a preg already in the list (or both slots freeing the same preg) SHALL be dropped and set dup_err; bitmap bits set on push, cleared on pop, reset to bits 32..63 set.
REQ-029 Without FREELIST_DUP_CHECK_EN: no bitmap, duplicates pushed unchecked, dup_err tied 0.

Structure
REQ-030 Shared package cpu_pkg SHALL hold PREG_W=6, NUM_PREG=64, NUM_ARCH=32 and the preg_t 6-bit typedef, shared with ROB and rename.
REQ-031 Entry storage SHALL be one sub-module fl_ram (1 async read port, 2 write ports); pointer/count control stays in phys_free_list.

Verification
REQ-032 Reset then alloc_req held 3 cycles -> alloc_preg 32,33,34; free_count 32->29.
REQ-033 Drain 32 allocs with no frees -> empty=1, free_count=0, alloc_gnt=0 on 33rd request.
REQ-034 From empty, free_valid_1=1 preg 40 and free_valid_2=1 preg 41 with alloc_req=1 -> gnt 0 that cycle; next cycle gnt 1, alloc_preg 40, then 41.
REQ-035 free_preg_1=0 valid with free_preg_2=5 valid -> only 5 pushed, count +1.
REQ-036 Fill to count 64 via frees, then two more frees -> both dropped, overflow_err=1 stays set until reset.
REQ-037 With FREELIST_DUP_CHECK_EN, free preg 50 while 50 still listed -> dropped, dup_err=1, count unchanged.
